inv_arbiter: RTL and testbench

//   Shares one multi-cycle Newton-Raphson reciprocal unit (INV, Q8.24) among N_REQ requesters
//   in the UKF datapath (e.g. innovation-covariance inverse, weight normalisation).

---
 rtl/inv_arb_pkg.sv | 27 ++
 rtl/inv_arbiter_rr.sv | 33 +++
 rtl/inv_arbiter.sv | 140 ++++++++++++++
 tb/tb_inv_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_arb_pkg.sv
// Shared types and Q-format constants for the reciprocal-unit arbiter.
// Optional non-positive divisor guard: define INV_ZERO_GUARD_EN.
package inv_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int Q_DATA_W    = 32;
    localparam int Q_FRAC_BITS = 24;

    localparam logic [Q_DATA_W-1:0] ONE     = Q_DATA_W'(1) << Q_FRAC_BITS;
    localparam logic [Q_DATA_W-1:0] SAT_MAX = {1'b0, {(Q_DATA_W-1){1'b1}}};

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Positive saturation for an arbitrary width, sliced down by the caller.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/inv_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr.
// Used by inv_arbiter; no clock, no state.
module rr_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/inv_arbiter.sv
// Round-robin sharing of one Newton-Raphson reciprocal unit among N_REQ ports.
// Optional non-positive divisor guard: define INV_ZERO_GUARD_EN.
module inv_arbiter
    import inv_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 24,
    parameter int N_REQ     = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_dd,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    inv_start,
    output logic [DATA_W-1:0]       inv_dd,
    input  logic [DATA_W-1:0]       inv_q,
    input  logic                    inv_done
);

    localparam int ID_W = id_width(N_REQ);

    if (FRAC_BITS >= DATA_W || N_REQ < 2 || N_REQ > 8) begin : g_cfg_err
        $error("inv_arbiter: unsupported DATA_W/FRAC_BITS/N_REQ");
    end

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  id_oh;
    logic [N_REQ-1:0]  gid_oh;
    logic [DATA_W-1:0] dd_sel;
    logic [DATA_W-1:0] res_r;
    logic              accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Gated by rstn so no port sees a ready strobe while reset is held.
    assign accept    = rstn && (state == S_IDLE) && (|req_valid);
    assign req_ready = accept ? grant : '0;
    assign busy      = (state != S_IDLE);
    assign dd_sel    = req_dd[int'(grant_id)*DATA_W +: DATA_W];

    assign id_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << id_r;
    assign gid_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign ptr_nxt = (id_r == ID_W'(N_REQ - 1)) ? '0 : id_r + 1'b1;

`ifdef INV_ZERO_GUARD_EN
    localparam logic [DATA_W-1:0] SAT = DATA_W'(sat_max(DATA_W));

    logic dd_bad;
    logic err_r;

    assign dd_bad  = dd_sel[DATA_W-1] || (dd_sel == '0);
    assign rsp_err = err_r;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            id_r      <= '0;
            res_r     <= '0;
            inv_start <= 1'b0;
            inv_dd    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
`ifdef INV_ZERO_GUARD_EN
            err_r     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        id_r <= grant_id;
`ifdef INV_ZERO_GUARD_EN
                        if (dd_bad) begin
                            rsp_valid <= gid_oh;
                            rsp_data  <= SAT;
                            err_r     <= 1'b1;
                            state     <= S_RESP;
                        end else
`endif
                        begin
                            inv_dd    <= dd_sel;
                            inv_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (inv_done) begin
                        res_r     <= inv_q;
                        inv_start <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                // A new start while done is still high would return a stale q.
                S_DRAIN: begin
                    if (!inv_done) begin
                        rsp_valid <= id_oh;
                        rsp_data  <= res_r;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    rsp_data  <= '0;
`ifdef INV_ZERO_GUARD_EN
                    err_r     <= 1'b0;
`endif
                    rr_ptr    <= ptr_nxt;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_gid_oh;
    assign unused_gid_oh = ^gid_oh;

endmodule

// File: tb/tb_inv_arbiter.sv
// Directed bench for inv_arbiter with a behavioural 3-iteration reciprocal unit.
// Checks grant order, response routing, reset abort and the divisor guard.
module tb_inv_arbiter;
    import inv_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_dd;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           inv_start;
    logic [W-1:0]   inv_dd;
    logic [W-1:0]   inv_q;
    logic           inv_done;

    always #5 clk = ~clk;

    inv_arbiter #(
        .DATA_W    (W),
        .FRAC_BITS (24),
        .N_REQ     (N)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_dd    (req_dd),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .inv_start (inv_start),
        .inv_dd    (inv_dd),
        .inv_q     (inv_q),
        .inv_done  (inv_done)
    );

    function automatic logic [W-1:0] nr(input logic [W-1:0] d);
        longint dl, x, t;
        dl = longint'($signed(d));
        x  = longint'(1) <<< 24;
        for (int k = 0; k < 3; k++) begin
            t = (dl * x) >>> 24;
            t = (longint'(2) <<< 24) - t;
            x = (x * t) >>> 24;
        end
        return x[W-1:0];
    endfunction

    // Reciprocal unit model: done holds until start is dropped.
    int           m_st;
    int           m_cnt;
    logic [W-1:0] m_d;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st     <= 0;
            m_cnt    <= 0;
            m_d      <= '0;
            inv_q    <= '0;
            inv_done <= 1'b0;
        end else begin
            case (m_st)
                0: if (inv_start) begin
                    m_d   <= inv_dd;
                    m_cnt <= LAT;
                    m_st  <= 1;
                end
                1: if (m_cnt == 0) begin
                    inv_q    <= nr(m_d);
                    inv_done <= 1'b1;
                    m_st     <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (!inv_start) begin
                    inv_done <= 1'b0;
                    m_st     <= 0;
                end
            endcase
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int   n_starts   = 0;
    logic start_prev = 1'b0;
    logic done_prev  = 1'b0;

    always @(negedge clk) begin
        if (rstn && inv_start && !start_prev) begin
            n_starts++;
            n_cmp++;
            assert (done_prev === 1'b0) else begin
                n_bad++;
                $error("FAIL start_while_done: observed done=%b expected 0",
                       done_prev);
            end
        end
        start_prev = inv_start;
        done_prev  = inv_done;
    end

    int           acc_ids[$];
    int           rsp_ids[$];
    logic [W-1:0] rsp_dat[$];
    logic         rsp_er[$];
    int           cyc_now;
    int           acc_cyc;
    int           rsp_cyc;

    function automatic int oh2id(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [W-1:0] atd(input logic [W-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clr();
        acc_ids.delete();
        rsp_ids.delete();
        rsp_dat.delete();
        rsp_er.delete();
        cyc_now = 0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d);
        req_valid[i]      = 1'b1;
        req_dd[i*W +: W]  = d;
    endtask

    // Call at posedge+1; returns at posedge+1.
    task automatic run(input int n_rsp, input int budget, input bit refill);
        int got = 0;
        int cyc = 0;
        int pend;
        while (got < n_rsp && cyc < budget) begin
            @(negedge clk);
            pend = -1;
            if (req_ready != '0) begin
                pend    = oh2id(req_ready);
                acc_ids.push_back(pend);
                acc_cyc = cyc_now;
            end
            if (rsp_valid != '0) begin
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                rsp_ids.push_back(oh2id(rsp_valid));
                rsp_dat.push_back(rsp_data);
                rsp_er.push_back(rsp_err);
                rsp_cyc = cyc_now;
                got++;
            end
            @(posedge clk);
            #1;
            if (pend >= 0 && !refill) req_valid[pend] = 1'b0;
            cyc++;
            cyc_now++;
        end
        chk("rsp_count", 64'(got), 64'(n_rsp));
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    logic [W-1:0] dd_tbl [N];
    logic [W-1:0] q_tbl  [N];
    int           s0;
    int           extra;
    bit           seen;

    initial begin
        dd_tbl = '{32'h0100_0000, 32'h0080_0000, 32'h00C0_0000, 32'h0040_0000};
        q_tbl  = '{32'h0100_0000, 32'h01FE_0000, 32'h0155_5400, 32'h0399_7C00};
        rstn      = 1'b0;
        req_valid = '0;
        req_dd    = '0;
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_inv_start", 64'(inv_start), 64'd0);
        chk("rst_inv_dd", 64'(inv_dd), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // 1: single request of 1.0 on port 0
        clr();
        set_req(0, ONE);
        run(1, 100, 1'b0);
        chk("t1_accepts", 64'(acc_ids.size()), 64'd1);
        chk("t1_acc_id", 64'(at(acc_ids, 0)), 64'd0);
        chk("t1_rsp_id", 64'(at(rsp_ids, 0)), 64'd0);
        chk("t1_rsp_data", 64'(atd(rsp_dat, 0)), 64'h0100_0000);
        chk("t1_rsp_err", 64'(rsp_er.size() > 0 ? rsp_er[0] : 1'bx), 64'd0);
        chk("t1_rsp_1cyc", 64'(rsp_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: 0.5 on port 1
        clr();
        set_req(1, 32'h0080_0000);
        run(1, 100, 1'b0);
        chk("t2_rsp_id", 64'(at(rsp_ids, 0)), 64'd1);
        chk("t2_rsp_data", 64'(atd(rsp_dat, 0)), 64'h01FE_0000);
        chk("t2_rsp_1cyc", 64'(rsp_valid), 64'd0);

        // 3: round-robin order after reset
        do_reset();
        clr();
        set_req(0, dd_tbl[0]);
        set_req(2, dd_tbl[2]);
        run(2, 200, 1'b0);
        chk("t3a_acc0", 64'(at(acc_ids, 0)), 64'd0);
        chk("t3a_acc1", 64'(at(acc_ids, 1)), 64'd2);
        chk("t3a_rsp1", 64'(at(rsp_ids, 1)), 64'd2);
        chk("t3a_data1", 64'(atd(rsp_dat, 1)), 64'(q_tbl[2]));
        clr();
        for (int i = 0; i < N; i++) set_req(i, dd_tbl[i]);
        run(4, 400, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3b_rsp_id%0d", k), 64'(at(rsp_ids, k)),
                64'((3 + k) % N));
            chk($sformatf("t3b_data%0d", k), 64'(atd(rsp_dat, k)),
                64'(q_tbl[(3 + k) % N]));
        end

        // 4: back-to-back on every port for 20 operations
        clr();
        for (int i = 0; i < N; i++) set_req(i, dd_tbl[i]);
        run(20, 2000, 1'b1);
        req_valid = '0;
        chk("t4_accepts", 64'(acc_ids.size()), 64'd20);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t4_acc%0d", k), 64'(at(acc_ids, k)), 64'((3 + k) % N));
            chk($sformatf("t4_rsp%0d", k), 64'(at(rsp_ids, k)), 64'((3 + k) % N));
            chk($sformatf("t4_data%0d", k), 64'(atd(rsp_dat, k)),
                64'(q_tbl[(3 + k) % N]));
        end

        // 5: reset while the unit is running
        clr();
        set_req(1, dd_tbl[1]);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (inv_start) seen = 1'b1;
        end
        chk("t5_issue_seen", 64'(seen), 64'd1);
        rstn      = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("t5_rst_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_inv_start", 64'(inv_start), 64'd0);
        chk("t5_rst_inv_dd", 64'(inv_dd), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_data", 64'(rsp_data), 64'd0);
        set_req(0, dd_tbl[0]);
        set_req(3, dd_tbl[3]);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        run(2, 200, 1'b0);
        chk("t5_first", 64'(at(acc_ids, 0)), 64'd0);
        chk("t5_second", 64'(at(rsp_ids, 1)), 64'd3);
        chk("t5_data0", 64'(atd(rsp_dat, 0)), 64'(q_tbl[0]));
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) extra++;
        end
        chk("t5_no_stale_rsp", 64'(extra), 64'd0);

        // 6: zero divisor on port 2
        @(posedge clk);
        #1;
        clr();
        s0 = n_starts;
        set_req(2, 32'h0000_0000);
        run(1, 100, 1'b0);
        chk("t6_rsp_id", 64'(at(rsp_ids, 0)), 64'd2);
`ifdef INV_ZERO_GUARD_EN
        chk("t6_data", 64'(atd(rsp_dat, 0)), 64'(SAT_MAX));
        chk("t6_err", 64'(rsp_er.size() > 0 ? rsp_er[0] : 1'bx), 64'd1);
        chk("t6_no_start", 64'(n_starts - s0), 64'd0);
        chk("t6_latency", 64'(rsp_cyc - acc_cyc), 64'd1);
`else
        chk("t6_data", 64'(atd(rsp_dat, 0)), 64'h0800_0000);
        chk("t6_err", 64'(rsp_er.size() > 0 ? rsp_er[0] : 1'bx), 64'd0);
        chk("t6_forwarded", 64'(n_starts - s0), 64'd1);
`endif
        chk("t6_rsp_1cyc", 64'(rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
